// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core's
// memory stage and the host/loader port; sequences fixed-latency reads.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic {IDLE, RD_WAIT} state_t;
  typedef enum logic {CORE, HOST} requester_t;

  state_t           state, stateNext;
  requester_t       owner, lastGrant, winner;
  logic [LAT_W-1:0] latCnt;
  logic             grant, winnerWe, readDone, coreDone;

  // Ties go to whoever was not granted last; lastGrant resets to HOST so the core wins first.
  always_comb begin
    winner = CORE;
    grant  = 1'b0;
    if (state == IDLE) begin
      if (core_req && host_req) begin
        winner = (lastGrant == HOST) ? CORE : HOST;
      end else if (host_req) begin
        winner = HOST;
      end
      grant = core_req | host_req;
    end
    winnerWe = (winner == HOST) ? host_we : core_we;
    readDone = (state == RD_WAIT) && (latCnt == '0);
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (grant && !winnerWe) stateNext = RD_WAIT;
      RD_WAIT: if (latCnt == '0) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Outputs are forced to zero while reset is held, even though state clears on the edge.
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    host_gnt   = 1'b0;
    core_stall = 1'b0;
    coreDone   = 1'b0;
    core_rdata = mem_rdata;
    if (reset) begin
      core_rdata = '0;
    end else begin
      if (grant) begin
        mem_en    = 1'b1;
        mem_we    = winnerWe;
        mem_addr  = (winner == HOST) ? host_addr : core_addr;
        mem_wdata = (winner == HOST) ? host_wdata : core_wdata;
        host_gnt  = (winner == HOST);
      end
      coreDone   = (grant && winner == CORE && core_we) || (readDone && owner == CORE);
      core_stall = core_req && !coreDone;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= CORE;
      lastGrant   <= HOST;
      latCnt      <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      state       <= stateNext;
      host_rvalid <= readDone && (owner == HOST);
      if (readDone && owner == HOST) host_rdata <= mem_rdata;
      if (grant) lastGrant <= winner;
      if (grant && !winnerWe) begin
        owner  <= winner;
        latCnt <= LAT_W'(RD_LAT - 1);
      end else if (state == RD_WAIT && latCnt != '0) begin
        latCnt <= latCnt - LAT_W'(1);
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters:
  - the pipelined core's memory stage (load/store);
  - a host/loader port used to preload programs and data and to read back results.
- Sits between the core's memory-stage outputs and the data memory.
- Sequences multi-cycle reads and generates a stall for the core pipeline.
- Resolves contention round-robin.

Parameters:
- ADDR_W, 32, address width for both requesters and memory.
- DATA_W, 32, data width.
- RD_LAT, 2, memory read latency in cycles (≥1): mem_rdata is valid RD_LAT cycles after the mem_en cycle.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- core_req  in  1  core memory-stage access request; held stable while core_stall=1.
- core_we  in  1  core write enable (store).
- core_addr  in  ADDR_W  core address.
- core_wdata  in  DATA_W  core store data.
- core_rdata  out  DATA_W  load data; valid when core_req & ~core_we & ~core_stall.
- core_stall  out  1  freezes the core pipeline.
- host_req  in  1  host request; held until host_gnt.
- host_we  in  1  host write enable.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  one-cycle pulse: request accepted.
- host_rvalid  out  1  one-cycle pulse: host_rdata valid.
- host_rdata  out  DATA_W  host read data (registered).
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- FSM states: IDLE, RD_WAIT. Internal registers: owner (CORE/HOST), lat_cnt, last_grant (CORE/HOST).
- Reset values:
  - state=IDLE, last_grant=HOST, so the core wins the first tie.
  - host_gnt=0, host_rvalid=0, host_rdata=0.
  - mem_en=mem_we=0, mem_addr=mem_wdata=0, core_stall=0.
- IDLE, no request: mem_en=0; core_stall=0.
- IDLE, exactly one requester: grant it this cycle.
- IDLE, both requesting: grant the requester that is not last_grant. last_grant updates on every grant.
- Grant cycle T:
  - mem_en=1; mem_we/mem_addr/mem_wdata combinationally from the winner.
  - host_gnt=1 if the winner is the host.
- Write grant: transaction completes at T; state stays IDLE.
  - If the core is the winner: core_stall=0 at T.
  - Next grant possible at T+1.
- Read grant: state→RD_WAIT, owner=winner, lat_cnt=RD_LAT-1.
  - RD_WAIT decrements lat_cnt each cycle; mem_en=0.
  - Completion cycle is T+RD_LAT (lat_cnt==0); state→IDLE at T+RD_LAT+1.
- Core read completion: at T+RD_LAT, core_rdata=mem_rdata (combinational) and core_stall=0.
- Host read completion: at T+RD_LAT+1, host_rvalid=1 and host_rdata=registered mem_rdata.
- core_stall=1 whenever core_req=1 and the core transaction does not complete this cycle, including:
  - host granted;
  - core read in RD_WAIT before completion;
  - host read in RD_WAIT.
- core_req=0 → core_stall=0.
- Read throughput: one read per RD_LAT+1 cycles. Writes are single-cycle.
- A request arriving during RD_WAIT waits; it is arbitrated in the first IDLE cycle.
- core_rdata in non-completion cycles: don't-care; drive mem_rdata.
- Reset asserted mid-read: return to IDLE; the pending read is abandoned and no host_rvalid or core completion is produced.
- Host dropping host_req before host_gnt is a protocol violation; behaviour undefined.
- No combinational path from mem_rdata to any host output.

Test Plan:
- Core store only, core_addr=0x10, core_wdata=0xDEADBEEF → mem_en=mem_we=1 same cycle, core_stall=0 throughout, mem_addr=0x10.
- Core load, RD_LAT=2, memory returns 0x12345678 → core_stall=1 for cycles T, T+1; at T+2 core_stall=0 and core_rdata=0x12345678; next grant no earlier than T+3.
- Host write 0xA5A5A5A5 to 0x20, then host read of 0x20 → host_gnt pulse on each grant; host_rvalid pulses at read-grant+3 with host_rdata=0xA5A5A5A5.
- Simultaneous core_req and host_req, both held for three rounds of writes after reset → grants in order CORE, HOST, CORE; core_stall=1 exactly in HOST grant cycles.
- Host read granted, then core_req asserted at T+1 → core_stall=1 through T+RD_LAT+1, core granted at T+RD_LAT+1.
- Reset at T+1 of a host read → no host_rvalid; all outputs zero during reset; next request granted normally with last_grant=HOST.
